// File: rtl/boot_rom_arbiter.sv
// Round-robin arbiter giving NB_PORTS requesters read-only access to a boot ROM.
// Writes are rejected with an error response; every transfer gets exactly one response one cycle later.
module boot_rom_arbiter #(
  parameter int ROM_ADDR_WIDTH = 13,
  parameter int NB_PORTS       = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NB_PORTS-1:0]           req_i,
  input  logic [NB_PORTS-1:0]           we_i,
  input  logic [NB_PORTS-1:0][31:0]     addr_i,
  output logic [NB_PORTS-1:0]           gnt_o,
  output logic [NB_PORTS-1:0]           r_valid_o,
  output logic [NB_PORTS-1:0]           r_opc_o,
  output logic [31:0]                   r_rdata_o,
  output logic                          rom_csn_o,
  output logic [ROM_ADDR_WIDTH-3:0]     rom_addr_o,
  input  logic [31:0]                   rom_rdata_i
);

  localparam int PW = $clog2(NB_PORTS);

  logic [PW-1:0] r_rrPtr;
  logic          r_respValid;
  logic [PW-1:0] r_respPort;
  logic          r_respErr;

  logic [PW-1:0] w_scanIdx;
  logic [PW-1:0] w_gntIdx;
  logic          w_gntFound;
  logic          w_isRead;
  logic [PW-1:0] w_rrNext;
  logic          w_unused;

  // Only the ROM word-address bits of addr_i are meaningful; the rest alias.
  assign w_unused = ^addr_i;

  always_comb begin
    w_gntFound = 1'b0;
    w_gntIdx   = '0;
    w_scanIdx  = '0;
    for (int k = 0; k < NB_PORTS; k++) begin
      w_scanIdx = PW'((int'(r_rrPtr) + k) % NB_PORTS);
      if (!w_gntFound && req_i[w_scanIdx]) begin
        w_gntFound = 1'b1;
        w_gntIdx   = w_scanIdx;
      end
    end
    if (rst_i) begin
      w_gntFound = 1'b0;
    end
  end

  always_comb begin
    gnt_o      = '0;
    w_isRead   = 1'b0;
    rom_csn_o  = 1'b1;
    rom_addr_o = '0;
    w_rrNext   = PW'((int'(w_gntIdx) + 1) % NB_PORTS);
    if (w_gntFound) begin
      gnt_o[w_gntIdx] = 1'b1;
      w_isRead        = !we_i[w_gntIdx];
    end
    if (w_isRead) begin
      rom_csn_o  = 1'b0;
      rom_addr_o = addr_i[w_gntIdx][ROM_ADDR_WIDTH-1:2];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rrPtr     <= '0;
      r_respValid <= 1'b0;
      r_respPort  <= '0;
      r_respErr   <= 1'b0;
    end else begin
      r_respValid <= w_gntFound;
      if (w_gntFound) begin
        r_rrPtr    <= w_rrNext;
        r_respPort <= w_gntIdx;
        r_respErr  <= we_i[w_gntIdx];
      end
    end
  end

  // Response is gated by reset so a transfer cut by reset never reports back.
  always_comb begin
    r_valid_o = '0;
    r_opc_o   = '0;
    r_rdata_o = '0;
    if (r_respValid && !rst_i) begin
      r_valid_o[r_respPort] = 1'b1;
      r_opc_o[r_respPort]   = r_respErr;
      r_rdata_o             = r_respErr ? 32'h0 : rom_rdata_i;
    end
  end

endmodule

// File: tb/tb_boot_rom_arbiter.sv
// Self-checking bench for boot_rom_arbiter: a 2-port and a 4-port instance checked
// every cycle against a behavioural model, plus hand-computed directed expectations.
module tb_boot_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  tReq [2];
  logic [3:0]  tWe  [2];
  logic [31:0] tAddr[2][4];

  logic [1:0]  gnt2, valid2, opc2;
  logic [31:0] rdata2, romData2;
  logic        csn2;
  logic [10:0] raddr2;

  logic [3:0]  gnt4, valid4, opc4;
  logic [31:0] rdata4, romData4;
  logic        csn4;
  logic [10:0] raddr4;

  int nChecks = 0;
  int nFails  = 0;

  // Model state per instance: index 0 is the 2-port DUT, index 1 the 4-port DUT.
  int          mRr[2];
  logic        mRv[2];
  int          mRp[2];
  logic        mRe[2];
  logic [10:0] mRa[2];

  initial forever #5 clk = ~clk;

  boot_rom_arbiter #(.ROM_ADDR_WIDTH(13), .NB_PORTS(2)) dut2 (
    .clk_i(clk), .rst_i(rst),
    .req_i(tReq[0][1:0]), .we_i(tWe[0][1:0]),
    .addr_i({tAddr[0][1], tAddr[0][0]}),
    .gnt_o(gnt2), .r_valid_o(valid2), .r_opc_o(opc2), .r_rdata_o(rdata2),
    .rom_csn_o(csn2), .rom_addr_o(raddr2), .rom_rdata_i(romData2)
  );

  boot_rom_arbiter #(.ROM_ADDR_WIDTH(13), .NB_PORTS(4)) dut4 (
    .clk_i(clk), .rst_i(rst),
    .req_i(tReq[1]), .we_i(tWe[1]),
    .addr_i({tAddr[1][3], tAddr[1][2], tAddr[1][1], tAddr[1][0]}),
    .gnt_o(gnt4), .r_valid_o(valid4), .r_opc_o(opc4), .r_rdata_o(rdata4),
    .rom_csn_o(csn4), .rom_addr_o(raddr4), .rom_rdata_i(romData4)
  );

  function automatic logic [31:0] romWord(input logic [10:0] a);
    return 32'hC0DE0000 | {21'b0, a};
  endfunction

  function automatic logic bitAt(input logic [3:0] v, input int i);
    return v[i[1:0]];
  endfunction

  // ROM models: data appears one cycle after a selected cycle.
  initial begin
    romData2 = 32'h0;
    romData4 = 32'h0;
  end
  always @(posedge clk) begin
    if (!csn2) romData2 <= romWord(raddr2);
    if (!csn4) romData4 <= romWord(raddr4);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] rq0, input logic [3:0] we0,
                               input logic [3:0] rq1, input logic [3:0] we1);
    @(posedge clk);
    #1;
    rst     = r;
    tReq[0] = rq0;
    tWe[0]  = we0;
    tReq[1] = rq1;
    tWe[1]  = we1;
  endtask

  // Model: first requester at/after the pointer wins; its response shows up next cycle.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int          n, g;
      logic [3:0]  eGnt, eValid, eOpc, aGnt, aValid, aOpc;
      logic        eCsn, aCsn;
      logic [10:0] eAddr, gAddr, aAddr;
      logic [31:0] eData, aData;
      n = (d == 0) ? 2 : 4;
      g = -1;
      eGnt = 4'b0; eValid = 4'b0; eOpc = 4'b0;
      eCsn = 1'b1; eAddr = 11'h0; gAddr = 11'h0; eData = 32'h0;
      if (!rst) begin
        for (int k = 0; k < n; k++) begin
          if (g < 0 && bitAt(tReq[d], (mRr[d] + k) % n)) g = (mRr[d] + k) % n;
        end
      end
      if (g >= 0) begin
        eGnt  = 4'b0001 << g;
        gAddr = 11'(tAddr[d][g[1:0]] >> 2);
        if (!bitAt(tWe[d], g)) begin
          eCsn  = 1'b0;
          eAddr = gAddr;
        end
      end
      if (!rst && mRv[d]) begin
        eValid = 4'b0001 << mRp[d];
        eOpc   = mRe[d] ? eValid : 4'b0;
        eData  = mRe[d] ? 32'h0 : romWord(mRa[d]);
      end
      aGnt   = (d == 0) ? {2'b0, gnt2}   : gnt4;
      aValid = (d == 0) ? {2'b0, valid2} : valid4;
      aOpc   = (d == 0) ? {2'b0, opc2}   : opc4;
      aData  = (d == 0) ? rdata2 : rdata4;
      aCsn   = (d == 0) ? csn2   : csn4;
      aAddr  = (d == 0) ? raddr2 : raddr4;
      checkOutput($sformatf("p%0d gnt", n),       32'(aGnt),   32'(eGnt));
      checkOutput($sformatf("p%0d r_valid", n),   32'(aValid), 32'(eValid));
      checkOutput($sformatf("p%0d r_opc", n),     32'(aOpc),   32'(eOpc));
      checkOutput($sformatf("p%0d r_rdata", n),   aData,       eData);
      checkOutput($sformatf("p%0d rom_csn", n),   32'(aCsn),   32'(eCsn));
      checkOutput($sformatf("p%0d rom_addr", n),  32'(aAddr),  32'(eAddr));
      if (rst) begin
        mRr[d] = 0;
        mRv[d] = 1'b0;
      end else begin
        mRv[d] = (g >= 0);
        if (g >= 0) begin
          mRr[d] = (g + 1) % n;
          mRp[d] = g;
          mRe[d] = bitAt(tWe[d], g);
          mRa[d] = gAddr;
        end
      end
    end
  end

  initial begin
    logic [3:0] seen;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      tReq[d] = 4'b0; tWe[d] = 4'b0;
      mRr[d] = 0; mRv[d] = 1'b0; mRp[d] = 0; mRe[d] = 1'b0; mRa[d] = 11'h0;
      for (int p = 0; p < 4; p++) tAddr[d][p] = 32'h0;
    end

    applyStimulus(1'b1, 4'b0, 4'b0, 4'b0, 4'b0);
    @(negedge clk);
    checkOutput("reset gnt", 32'(gnt2), 32'h0);
    checkOutput("reset csn", 32'(csn2), 32'h1);
    checkOutput("reset valid", 32'(valid2), 32'h0);
    applyStimulus(1'b0, 4'b0, 4'b0, 4'b0, 4'b0);

    // Single read from port 0
    applyStimulus(1'b0, 4'b0001, 4'b0, 4'b0, 4'b0);
    tAddr[0][0] = 32'h1A000084;
    @(negedge clk);
    checkOutput("read gnt", 32'(gnt2), 32'h1);
    checkOutput("read csn", 32'(csn2), 32'h0);
    checkOutput("read addr", 32'(raddr2), 32'h021);
    applyStimulus(1'b0, 4'b0, 4'b0, 4'b0, 4'b0);
    @(negedge clk);
    checkOutput("read rvalid", 32'(valid2), 32'h1);
    checkOutput("read rdata", rdata2, 32'hC0DE0021);
    checkOutput("read ropc", 32'(opc2), 32'h0);
    checkOutput("idle addr", 32'(raddr2), 32'h0);

    // Write from port 1 is rejected
    applyStimulus(1'b0, 4'b0010, 4'b0010, 4'b0, 4'b0);
    tAddr[0][1] = 32'h0;
    @(negedge clk);
    checkOutput("write gnt", 32'(gnt2), 32'h2);
    checkOutput("write csn", 32'(csn2), 32'h1);
    applyStimulus(1'b0, 4'b0, 4'b0, 4'b0, 4'b0);
    @(negedge clk);
    checkOutput("write rvalid", 32'(valid2), 32'h2);
    checkOutput("write ropc", 32'(opc2), 32'h2);
    checkOutput("write rdata", rdata2, 32'h0);

    // Contention: grants alternate, responses follow one cycle behind
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 4'b0011, 4'b0, 4'b0, 4'b0);
      tAddr[0][0] = 32'h100 + 32'(i * 8);
      tAddr[0][1] = 32'h200 + 32'(i * 4);
      @(negedge clk);
      checkOutput("contend gnt", 32'(gnt2), (i % 2 == 1) ? 32'h2 : 32'h1);
      if (i > 0) checkOutput("contend rvalid", 32'(valid2), (i % 2 == 1) ? 32'h1 : 32'h2);
    end
    applyStimulus(1'b0, 4'b0, 4'b0, 4'b0, 4'b0);
    @(negedge clk);
    checkOutput("contend last rvalid", 32'(valid2), 32'h2);

    // Address aliasing above the ROM width
    applyStimulus(1'b0, 4'b0010, 4'b0, 4'b0, 4'b0);
    tAddr[0][1] = 32'h00002004;
    @(negedge clk);
    checkOutput("wrap gnt", 32'(gnt2), 32'h2);
    checkOutput("wrap addr", 32'(raddr2), 32'h001);

    // Reset right after a grant cancels its response and rewinds the pointer
    applyStimulus(1'b0, 4'b0001, 4'b0, 4'b0, 4'b0);
    tAddr[0][0] = 32'h40;
    @(negedge clk);
    checkOutput("rstmid gnt", 32'(gnt2), 32'h1);
    applyStimulus(1'b1, 4'b0011, 4'b0, 4'b1111, 4'b0);
    @(negedge clk);
    checkOutput("rstmid rvalid", 32'(valid2), 32'h0);
    checkOutput("rst+req gnt", 32'(gnt2), 32'h0);
    checkOutput("rst+req csn", 32'(csn2), 32'h1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 4'b0, 4'b0, 4'b0, 4'b0);
      @(negedge clk);
      checkOutput("post-rst rvalid", 32'(valid2), 32'h0);
    end
    applyStimulus(1'b0, 4'b0011, 4'b0, 4'b0, 4'b0);
    @(negedge clk);
    checkOutput("post-rst rr gnt", 32'(gnt2), 32'h1);
    applyStimulus(1'b0, 4'b0, 4'b0, 4'b0, 4'b0);

    // Four-port fairness: each port exactly once per four cycles
    seen = 4'b0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 4'b0, 4'b0, 4'b1111, 4'b0100);
      for (int p = 0; p < 4; p++) tAddr[1][p] = 32'h1000 * 32'(p + 1) + 32'(i * 4);
      @(negedge clk);
      checkOutput("fair gnt", 32'(gnt4), 32'h1 << (i % 4));
      seen = seen | gnt4;
      if (i % 4 == 3) begin
        checkOutput("fair window", 32'(seen), 32'hF);
        seen = 4'b0;
      end
    end

    // Mixed traffic on both instances, checked by the model
    for (int i = 0; i < 40; i++) begin
      applyStimulus(($urandom_range(0, 12) == 0), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      for (int d = 0; d < 2; d++)
        for (int p = 0; p < 4; p++) tAddr[d][p] = $urandom;
    end
    applyStimulus(1'b0, 4'b0, 4'b0, 4'b0, 4'b0);
    applyStimulus(1'b0, 4'b0, 4'b0, 4'b0, 4'b0);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
